// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the AHB-to-APB bridge.
//   apb_state_e  : APB sequencer state encoding (IDLE..ERR2)
//   HRESP_*      : AHB response codes
//   HTRANS_*     : AHB transfer-type codes (used by the AHB slave interface)
//   hresp_for()  : maps a sequencer state to its AHB response
// ---------------------------------------------------------------------------
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    ERR1   = 3'd3,
    ERR2   = 3'd4
  } apb_state_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // The two-cycle ERROR response spans both error states; everything else
  // answers OKAY.
  function automatic logic [1:0] hresp_for(input apb_state_e s);
    return ((s == ERR1) || (s == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ---------------------------------------------------------------------------
// apb_timeout_counter
// Counts ENABLE cycles spent waiting for PREADY.
//   hclk     : bridge clock
//   hresetn  : synchronous active-low reset
//   clear    : restart the count at zero (takes priority over enable)
//   enable   : advance the count by one
//   terminal : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module apb_timeout_counter #(
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/apb_transfer_controller.sv
// ---------------------------------------------------------------------------
// apb_transfer_controller
// APB-side sequencer of the AHB-to-APB bridge. Runs one SETUP->ENABLE APB
// access per registered AHB request, stretches the AHB data phase, converts
// PSLVERR, a bad slave index or a PREADY timeout into a two-cycle AHB ERROR.
//   hclk, hresetn        : clock, synchronous active-low reset
//   valid                : registered transfer request
//   haddr1/hwritereg     : latched address / direction (1 = write)
//   tempselx             : latched slave index
//   hwdata               : AHB write data (data phase)
//   prdata/pready/pslverr: APB slave response
//   pselx/penable/pwrite/paddr/pwdata : registered APB request
//   hreadyout/hresp/hrdata            : AHB response (combinational)
// ---------------------------------------------------------------------------
module apb_transfer_controller
  import bridge_pkg::*;
#(
  parameter int NSLV    = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            valid,
  input  logic [31:0]     haddr1,
  input  logic            hwritereg,
  input  logic [2:0]      tempselx,
  input  logic [31:0]     hwdata,
  input  logic [31:0]     prdata,
  input  logic            pready,
  input  logic            pslverr,
  output logic [NSLV-1:0] pselx,
  output logic            penable,
  output logic            pwrite,
  output logic [31:0]     paddr,
  output logic [31:0]     pwdata,
  output logic            hreadyout,
  output logic [1:0]      hresp,
  output logic [31:0]     hrdata
);

  // Four bits hold NSLV up to 8 so the range check never truncates.
  localparam logic [3:0] NSLV_L = 4'(NSLV);

  apb_state_e      state, state_d;
  logic [NSLV-1:0] pselx_d, sel_dec;
  logic            penable_d, pwrite_d;
  logic [31:0]     paddr_d, pwdata_d;
  logic            bad_sel;
  logic            cnt_clear, cnt_en, cnt_tc;

  assign bad_sel = ({1'b0, tempselx} >= NSLV_L);

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_dec[i] = (tempselx == 3'(i));
    end
  end

  apb_timeout_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_tc)
  );

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state;
    pselx_d   = pselx;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    hreadyout = 1'b1;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    unique case (state)
      IDLE: begin
        hreadyout = !valid;
        if (valid) begin
          if (bad_sel) begin
            // Nothing is put on the APB bus for an unmapped slave.
            state_d = ERR1;
          end else begin
            state_d  = SETUP;
            paddr_d  = haddr1;
            pwrite_d = hwritereg;
            pselx_d  = sel_dec;
            // Write data is only present in this data-phase cycle.
            if (hwritereg) pwdata_d = hwdata;
          end
        end
      end

      SETUP: begin
        hreadyout = 1'b0;
        penable_d = 1'b1;
        cnt_clear = 1'b1;
        state_d   = ENABLE;
      end

      ENABLE: begin
        hreadyout = pready & !pslverr;
        if (pready) begin
          pselx_d   = '0;
          penable_d = 1'b0;
          state_d   = pslverr ? ERR1 : IDLE;
        end else begin
          cnt_en = 1'b1;
          // The counter lags the ENABLE cycle count by one, so terminal
          // here means this is the TIMEOUT-th ENABLE cycle.
          if (cnt_tc) begin
            pselx_d   = '0;
            penable_d = 1'b0;
            state_d   = ERR1;
          end
        end
      end

      ERR1: begin
        hreadyout = 1'b0;
        state_d   = ERR2;
      end

      ERR2: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state   <= IDLE;
      pselx   <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      state   <= state_d;
      pselx   <= pselx_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
    end
  end

  assign hresp  = hresp_for(state);
  assign hrdata = ((state == ENABLE) && pready) ? prdata : 32'h0;

endmodule

// File: tb/tb_apb_transfer_controller.sv
// ---------------------------------------------------------------------------
// tb_apb_transfer_controller
// Directed stimulus with a scoreboard: each request pushes its hand-computed
// AHB/APB outcome; a negedge monitor pops and compares on every completion
// (hreadyout high with penable or ERROR).
// ---------------------------------------------------------------------------
module tb_apb_transfer_controller;

  localparam int NSLV    = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic            valid;
  logic [31:0]     haddr1;
  logic            hwritereg;
  logic [2:0]      tempselx;
  logic [31:0]     hwdata;
  logic [31:0]     prdata;
  logic            pready;
  logic            pslverr;
  logic [NSLV-1:0] pselx;
  logic            penable;
  logic            pwrite;
  logic [31:0]     paddr;
  logic [31:0]     pwdata;
  logic            hreadyout;
  logic [1:0]      hresp;
  logic [31:0]     hrdata;

  apb_transfer_controller #(
    .NSLV    (NSLV),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .haddr1    (haddr1),
    .hwritereg (hwritereg),
    .tempselx  (tempselx),
    .hwdata    (hwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    int          stall;    // hreadyout-low cycles before completion
    int          enables;  // cycles with penable high
    logic [3:0]  sel;      // OR of all pselx seen
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    bit          has_apb;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk_exp(input logic [1:0] r, input logic [31:0] d, input int st,
                                  input int en, input logic [3:0] s, input logic [31:0] a,
                                  input logic w, input logic [31:0] wd, input bit apb);
    exp_t e;
    e.hresp = r; e.hrdata = d; e.stall = st; e.enables = en; e.sel = s;
    e.paddr = a; e.pwrite = w; e.pwdata = wd; e.has_apb = apb;
    return e;
  endfunction

  // Monitor accumulators for the transfer currently in flight.
  int          m_stall, m_en;
  logic [3:0]  m_sel;
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pwrite, m_stable, m_setup;

  task automatic m_clear();
    m_stall = 0; m_en = 0; m_sel = '0; m_paddr = '0; m_pwdata = '0;
    m_pwrite = 1'b0; m_stable = 1'b1; m_setup = 1'b0;
  endtask

  always @(negedge hclk) begin
    if (!hresetn) begin
      m_clear();
    end else begin
      if (hresp == 2'b01) begin
        check("err_pselx_low", 32'(pselx), 32'h0);
        check("err_penable_low", 32'(penable), 32'h0);
      end
      m_sel = m_sel | pselx;
      if (pselx != '0 && !penable) begin
        m_setup = 1'b1; m_paddr = paddr; m_pwrite = pwrite; m_pwdata = pwdata;
      end
      if (penable) begin
        m_en++;
        if (paddr !== m_paddr || pwrite !== m_pwrite || pwdata !== m_pwdata || !m_setup)
          m_stable = 1'b0;
      end
      if (!hreadyout) begin
        m_stall++;
      end else if (penable || hresp == 2'b01) begin
        check("sb_expected", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("hresp", 32'(hresp), 32'(e.hresp));
          check("hrdata", hrdata, e.hrdata);
          check("stall_cycles", 32'(m_stall), 32'(e.stall));
          check("enable_cycles", 32'(m_en), 32'(e.enables));
          check("pselx_seen", 32'(m_sel), 32'(e.sel));
          if (e.has_apb) begin
            check("setup_seen", 32'(m_setup), 32'h1);
            check("paddr", m_paddr, e.paddr);
            check("pwrite", 32'(m_pwrite), 32'(e.pwrite));
            check("pwdata", m_pwdata, e.pwdata);
            check("apb_stable", 32'(m_stable), 32'h1);
          end
        end
        m_clear();
      end else begin
        m_clear();
      end
    end
  end

  // waits < 0 holds pready low until the timeout fires.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sel,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits, input bit err);
    prdata = rdata; haddr1 = addr; hwritereg = wr; tempselx = sel; hwdata = wdata;
    valid = 1'b1;
    @(posedge hclk); #1;
    // Scramble the request inputs: the APB side must hold what it latched.
    valid = 1'b0; hwdata = 32'h0; haddr1 = 32'hFFFF_FFFF; hwritereg = ~wr;
    if (sel < 3'(NSLV)) begin
      pready = 1'b0; pslverr = 1'b0;
      @(posedge hclk); #1;
      if (waits < 0) begin
        repeat (TIMEOUT + 2) @(posedge hclk);
        #1;
      end else begin
        for (int k = 1; k <= waits + 1; k++) begin
          pready  = (k > waits);
          pslverr = err && (k > waits);
          @(posedge hclk); #1;
        end
      end
      pready = 1'b0; pslverr = 1'b0;
    end
    repeat (4) @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0; valid = 1'b0; haddr1 = '0; hwritereg = 1'b0; tempselx = '0;
    hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    check("rst_pselx", 32'(pselx), 32'h0);
    check("rst_penable", 32'(penable), 32'h0);
    check("rst_pwrite", 32'(pwrite), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;

    // Zero-wait read to slave 2.
    sb.push_back(mk_exp(2'b00, 32'hCAFE_0001, 2, 1, 4'b0100, 32'h0000_0010, 1'b0, 32'h0, 1'b1));
    run_xfer(32'h0000_0010, 1'b0, 3'd2, 32'h0, 32'hCAFE_0001, 0, 1'b0);

    // Write to slave 1 with 3 wait states; hrdata mirrors prdata.
    sb.push_back(mk_exp(2'b00, 32'hDEAD_BEEF, 5, 4, 4'b0010, 32'h0000_0020, 1'b1, 32'h1234_5678, 1'b1));
    run_xfer(32'h0000_0020, 1'b1, 3'd1, 32'h1234_5678, 32'hDEAD_BEEF, 3, 1'b0);

    // Read that gets PSLVERR; pwdata keeps the previous write value.
    sb.push_back(mk_exp(2'b01, 32'h0, 4, 1, 4'b1000, 32'h0000_0030, 1'b0, 32'h1234_5678, 1'b1));
    run_xfer(32'h0000_0030, 1'b0, 3'd3, 32'hAAAA_AAAA, 32'h5555_5555, 0, 1'b1);

    // Hung slave: 16 ENABLE cycles then ERROR.
    sb.push_back(mk_exp(2'b01, 32'h0, 19, 16, 4'b0001, 32'h0000_0040, 1'b0, 32'h1234_5678, 1'b1));
    run_xfer(32'h0000_0040, 1'b0, 3'd0, 32'h0, 32'h0, -1, 1'b0);

    // Unmapped slave index: no APB access, immediate ERROR.
    sb.push_back(mk_exp(2'b01, 32'h0, 2, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0));
    run_xfer(32'h0000_0070, 1'b0, 3'd7, 32'h0, 32'h0, 0, 1'b0);

    // Reset while ENABLE is waiting on pready.
    prdata = 32'h0; haddr1 = 32'h0000_0060; hwritereg = 1'b1; tempselx = 3'd2;
    hwdata = 32'h9999_0000; pready = 1'b0; valid = 1'b1;
    @(posedge hclk); #1;
    valid = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    check("midrst_pselx", 32'(pselx), 32'h0);
    check("midrst_penable", 32'(penable), 32'h0);
    check("midrst_pwrite", 32'(pwrite), 32'h0);
    check("midrst_paddr", paddr, 32'h0);
    check("midrst_pwdata", pwdata, 32'h0);
    check("midrst_hreadyout", 32'(hreadyout), 32'h1);
    check("midrst_hresp", 32'(hresp), 32'h0);
    repeat (TIMEOUT + 4) @(posedge hclk);
    #1;

    // Normal read after the abandoned access.
    sb.push_back(mk_exp(2'b00, 32'h0BAD_F00D, 2, 1, 4'b0010, 32'h0000_0050, 1'b0, 32'h0, 1'b1));
    run_xfer(32'h0000_0050, 1'b0, 3'd1, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
